aes_encrypt_ctrl: RTL and testbench
===================================

AES_ENCRYPT_CTRL -- requirements
Module: aes_encrypt_ctrl

Interface
REQ-001 SHALL have parameter NR_MAX, default 14, the maximum round count; Round saturates at this value.
REQ-002 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Start  input  1  request to begin one block encryption.
REQ-005 SHALL have port KeyLen  input  2  key size: 00=128 (Nr=10), 01=192 (Nr=12), 10/11=256 (Nr=14).
REQ-006 SHALL have port Ack  input  1  consumer acknowledge of Done.
REQ-007 SHALL have port Abort  input  1  cancel the current operation.
REQ-008 SHALL have port Ready  output  1  high only in IDLE; Start is accepted when Start&Ready.
REQ-009 SHALL have port Busy  output  1  high in INIT, ROUND and FINAL.
REQ-010 SHALL have port Round  output  4  current round index driven to the datapath and key schedule.
REQ-011 SHALL have port Load_State  output  1  datapath loads plaintext; high only in INIT.
REQ-012 SHALL have port Sel_Initial  output  1  datapath does AddRoundKey only; high only in INIT.
REQ-013 SHALL have port Skip_MixCol  output  1  datapath bypasses MixColumns; high only in FINAL.
REQ-014 SHALL have port Key_En  output  1  key-schedule advance strobe; high in INIT, ROUND, FINAL.
REQ-015 SHALL have port Done  output  1  ciphertext valid; high in DONE until acknowledged.

Function
REQ-016 SHALL implement states IDLE, INIT, ROUND, FINAL, DONE; all outputs are registered or decoded from state and Round only.
REQ-017 SHALL, in IDLE on Start=1, latch Nr from KeyLen and go to INIT next cycle; Round=0 in INIT.
REQ-018 SHALL go INIT->ROUND with Round=1, then increment Round by 1 per cycle in ROUND while Round<Nr-1.
REQ-019 SHALL go ROUND->FINAL when Round=Nr-1, with Round=Nr in FINAL, then FINAL->DONE.
REQ-020 SHALL give latency: Start accepted at cycle T, INIT at T+1, FINAL at T+Nr+1, Done first high at T+Nr+2.
REQ-021 SHALL hold Done=1 and Round=Nr in DONE until Ack=1, then go to IDLE next cycle with Round=0.
REQ-022 SHALL ignore Start outside IDLE and Ack outside DONE; KeyLen changes after acceptance have no effect.
REQ-023 SHALL, on Abort=1 in any non-IDLE state, go to IDLE next cycle with Round=0 and no Done pulse.
REQ-024 SHALL give priority Rst > Abort > Ack > Start; Start with Abort in IDLE is not accepted.
REQ-025 SHALL never let Round exceed NR_MAX; any state/Round combination not reachable through REQ-016..REQ-023 returns to IDLE next cycle.
REQ-026 SHALL accept a new Start in the cycle after Ack-driven return to IDLE (back-to-back blocks, one idle cycle).

Reset
REQ-027 SHALL, when Rst=1 at a rising Clk edge, enter IDLE with Round=0, Ready=1, all other outputs 0; Rst overrides every input, including mid-operation.
REQ-028 SHALL latch Nr=14 on reset.

Configuration
REQ-029 SHALL, with macro AES_KEYLEN_SEL_EN defined, derive Nr from KeyLen per REQ-005.
REQ-030 SHALL, without AES_KEYLEN_SEL_EN, keep the KeyLen port, ignore it, and fix Nr=14 (AES-256 only).

Verification
REQ-031 SHALL cover: Rst=1 then Start=1, KeyLen=00 at T -> INIT at T+1, Round 1..9 at T+2..T+10, FINAL Round=10 at T+11 with Skip_MixCol=1, Done at T+12.
REQ-032 SHALL cover: KeyLen=01 and KeyLen=10 -> Done at T+14 and T+16; with the macro undefined, KeyLen=00 -> Done at T+16.
REQ-033 SHALL cover: Ack withheld 5 cycles -> Done and Round=Nr held 5 cycles; Ack -> IDLE next cycle; Start the following cycle accepted.
REQ-034 SHALL cover: Abort at Round=5 -> IDLE next cycle, Round=0, Done never asserted; Abort and Ack together in DONE -> IDLE, Abort wins.
REQ-035 SHALL cover: Rst=1 asserted at Round=7 -> next cycle IDLE, Round=0, Ready=1, Busy=0; Start during ROUND -> ignored, sequence unchanged.

Source files
------------

// File: rtl/aes_encrypt_ctrl.sv
// -----------------------------------------------------------------------------
// aes_encrypt_ctrl
//
// Purpose
//   Round sequencer for an iterative AES block encryption core. It steps the
//   datapath through the initial AddRoundKey (INIT), the Nr-1 full rounds
//   (ROUND), and the final round without MixColumns (FINAL). It then holds the
//   result valid (DONE) until the consumer acknowledges it.
//
// Configuration macro
//   AES_KEYLEN_SEL_EN  defined   : Nr is taken from KeyLen when Start is
//                                  accepted (00->10, 01->12, 10/11->14).
//                      undefined : KeyLen is ignored and Nr is fixed at 14
//                                  (AES-256 only).
//
// Parameters
//   NR_MAX       maximum round count. Round and the latched Nr never exceed it.
//
// Ports
//   Clk          in   single clock. All state changes on its rising edge.
//   Rst          in   synchronous, active-high reset.
//   Start        in   begin one block. Accepted when Start & Ready.
//   KeyLen[1:0]  in   key size select. Sampled only when Start is accepted.
//   Ack          in   consumer acknowledge of Done. Only observed in DONE.
//   Abort        in   cancel the current operation. Returns to IDLE.
//   Ready        out  high only in IDLE.
//   Busy         out  high in INIT, ROUND and FINAL.
//   Round[3:0]   out  current round index for the datapath and key schedule.
//   Load_State   out  datapath loads plaintext. High only in INIT.
//   Sel_Initial  out  datapath performs AddRoundKey only. High only in INIT.
//   Skip_MixCol  out  datapath bypasses MixColumns. High only in FINAL.
//   Key_En       out  key-schedule advance strobe. High in INIT/ROUND/FINAL.
//   Done         out  ciphertext valid. Held in DONE until Ack.
// -----------------------------------------------------------------------------
module aes_encrypt_ctrl #(
    parameter int NR_MAX = 14
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [1:0] KeyLen,
    input  logic       Ack,
    input  logic       Abort,
    output logic       Ready,
    output logic       Busy,
    output logic [3:0] Round,
    output logic       Load_State,
    output logic       Sel_Initial,
    output logic       Skip_MixCol,
    output logic       Key_En,
    output logic       Done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] NR_CAP = 4'(NR_MAX);

    // Clamp a round count so that neither Nr nor Round can pass NR_MAX.
    function automatic logic [3:0] sat_nr(input logic [3:0] nr);
        return (nr > NR_CAP) ? NR_CAP : nr;
    endfunction

    localparam logic [3:0] NR_RST = (4'd14 > NR_CAP) ? NR_CAP : 4'd14;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] nr_q, nr_d;
    logic [3:0] nr_sel;
    logic       nr_ok;

`ifdef AES_KEYLEN_SEL_EN
    always_comb begin
        case (KeyLen)
            2'b00:   nr_sel = sat_nr(4'd10);
            2'b01:   nr_sel = sat_nr(4'd12);
            default: nr_sel = sat_nr(4'd14);
        endcase
    end
`else
    // KeyLen stays on the port for drop-in compatibility but has no effect.
    logic unused_keylen;
    assign unused_keylen = ^KeyLen;
    assign nr_sel        = sat_nr(4'd14);
`endif

    // Next-state logic. Any combination of state, Round and Nr that the
    // normal sequence cannot produce falls back to IDLE with Round=0.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        // A latched Nr below 2 would leave no full rounds and break the
        // Nr-1 comparison, so it is treated as corrupt.
        nr_ok   = (nr_q >= 4'd2) && (nr_q <= NR_CAP);

        case (state_q)
            S_IDLE: begin
                round_d = 4'd0;
                // Abort outranks Start, so a simultaneous pair is not accepted.
                if (Start && !Abort) begin
                    state_d = S_INIT;
                    nr_d    = nr_sel;
                end
            end

            S_INIT: begin
                if (Abort || !nr_ok || (round_q != 4'd0)) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end else begin
                    state_d = S_ROUND;
                    round_d = 4'd1;
                end
            end

            S_ROUND: begin
                if (Abort || !nr_ok || (round_q == 4'd0) || (round_q >= nr_q)) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end else if (round_q == 4'(nr_q - 4'd1)) begin
                    state_d = S_FINAL;
                    round_d = nr_q;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            S_FINAL: begin
                if (Abort || !nr_ok || (round_q != nr_q)) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // Abort and Ack both lead to IDLE. Abort is listed first
                // because it has the higher priority.
                if (Abort || Ack || !nr_ok || (round_q != nr_q)) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State register. The outputs are registered from the next state, so
    // each one matches a plain decode of the current state with no
    // combinational path from the inputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            round_q     <= 4'd0;
            nr_q        <= NR_RST;
            Ready       <= 1'b1;
            Busy        <= 1'b0;
            Load_State  <= 1'b0;
            Sel_Initial <= 1'b0;
            Skip_MixCol <= 1'b0;
            Key_En      <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            nr_q        <= nr_d;
            Ready       <= (state_d == S_IDLE);
            Busy        <= (state_d == S_INIT) || (state_d == S_ROUND) || (state_d == S_FINAL);
            Load_State  <= (state_d == S_INIT);
            Sel_Initial <= (state_d == S_INIT);
            Skip_MixCol <= (state_d == S_FINAL);
            Key_En      <= (state_d == S_INIT) || (state_d == S_ROUND) || (state_d == S_FINAL);
            Done        <= (state_d == S_DONE);
        end
    end

    assign Round = round_q;

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_encrypt_ctrl
//
// Directed bench for aes_encrypt_ctrl. Outputs are sampled 1 ns after each
// rising edge and compared with hand-derived per-state output patterns and
// round indices.
// -----------------------------------------------------------------------------
module tb_aes_encrypt_ctrl;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic [1:0] KeyLen;
    logic       Ack;
    logic       Abort;
    logic       Ready;
    logic       Busy;
    logic [3:0] Round;
    logic       Load_State;
    logic       Sel_Initial;
    logic       Skip_MixCol;
    logic       Key_En;
    logic       Done;

    int errors = 0;
    int checks = 0;

    localparam int ST_IDLE  = 0;
    localparam int ST_INIT  = 1;
    localparam int ST_ROUND = 2;
    localparam int ST_FINAL = 3;
    localparam int ST_DONE  = 4;

    aes_encrypt_ctrl #(.NR_MAX(14)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Start       (Start),
        .KeyLen      (KeyLen),
        .Ack         (Ack),
        .Abort       (Abort),
        .Ready       (Ready),
        .Busy        (Busy),
        .Round       (Round),
        .Load_State  (Load_State),
        .Sel_Initial (Sel_Initial),
        .Skip_MixCol (Skip_MixCol),
        .Key_En      (Key_En),
        .Done        (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected round count for a KeyLen value in this build.
    function automatic int exp_nr(input logic [1:0] kl);
`ifdef AES_KEYLEN_SEL_EN
        case (kl)
            2'b00:   return 10;
            2'b01:   return 12;
            default: return 14;
        endcase
`else
        if (kl == 2'b11) return 14;
        return 14;
`endif
    endfunction

    // {Ready, Busy, Load_State, Sel_Initial, Skip_MixCol, Key_En, Done}
    function automatic logic [6:0] exp_vec(input int st);
        case (st)
            ST_IDLE:  return 7'b1000000;
            ST_INIT:  return 7'b0111010;
            ST_ROUND: return 7'b0100010;
            ST_FINAL: return 7'b0100110;
            ST_DONE:  return 7'b0000001;
            default:  return 7'b0000000;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int st, input int rnd);
        chk({tag, ".outs"}, 32'({Ready, Busy, Load_State, Sel_Initial, Skip_MixCol, Key_En, Done}),
            32'(exp_vec(st)));
        chk({tag, ".round"}, 32'(Round), 32'(rnd));
    endtask

    // Start held for one cycle. KeyLen is changed right after acceptance
    // to confirm it is not resampled.
    task automatic accept(input logic [1:0] kl);
        Start  = 1'b1;
        KeyLen = kl;
        tick();
        Start  = 1'b0;
        KeyLen = ~kl;
        chk_state("init", ST_INIT, 0);
    endtask

    // Step through full rounds first..last. With glitch set, Start and Ack
    // pulse during the cycle that leads into round 3 and must be ignored.
    task automatic rounds(input int first, input int last, input bit glitch);
        for (int r = first; r <= last; r++) begin
            if (glitch && r == 3) begin
                Start = 1'b1;
                Ack   = 1'b1;
            end
            tick();
            Start = 1'b0;
            Ack   = 1'b0;
            chk_state($sformatf("round%0d", r), ST_ROUND, r);
        end
    endtask

    task automatic finish_block(input int nr);
        tick();
        chk_state("final", ST_FINAL, nr);
        tick();
        chk_state("done", ST_DONE, nr);
    endtask

    initial begin
        Rst    = 1'b1;
        Start  = 1'b0;
        KeyLen = 2'b00;
        Ack    = 1'b0;
        Abort  = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        chk_state("reset", ST_IDLE, 0);
        tick();
        chk_state("idle_hold", ST_IDLE, 0);

        // KeyLen=00 block with ignored Start/Ack during ROUND, then Ack.
        accept(2'b00);
        rounds(1, exp_nr(2'b00) - 1, 1'b1);
        finish_block(exp_nr(2'b00));
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk_state("ack_idle_a", ST_IDLE, 0);

        // KeyLen=01 block with Ack withheld for 5 cycles.
        accept(2'b01);
        rounds(1, exp_nr(2'b01) - 1, 1'b0);
        finish_block(exp_nr(2'b01));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_state($sformatf("done_hold%0d", i), ST_DONE, exp_nr(2'b01));
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk_state("ack_idle_b", ST_IDLE, 0);

        // Back-to-back: Start in the first idle cycle. KeyLen=10, then
        // Abort and Ack together in DONE.
        accept(2'b10);
        rounds(1, exp_nr(2'b10) - 1, 1'b0);
        finish_block(exp_nr(2'b10));
        Abort = 1'b1;
        Ack   = 1'b1;
        tick();
        Abort = 1'b0;
        Ack   = 1'b0;
        chk_state("abort_ack_done", ST_IDLE, 0);
        tick();
        chk_state("abort_ack_after", ST_IDLE, 0);

        // Abort at Round=5.
        accept(2'b10);
        rounds(1, 5, 1'b0);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk_state("abort_r5", ST_IDLE, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_state($sformatf("abort_quiet%0d", i), ST_IDLE, 0);
        end

        // Start with Abort in IDLE is not accepted.
        Start = 1'b1;
        Abort = 1'b1;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        chk_state("start_abort_idle", ST_IDLE, 0);

        // Abort in INIT.
        accept(2'b01);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk_state("abort_init", ST_IDLE, 0);

        // Rst at Round=7 overrides everything.
        accept(2'b11);
        rounds(1, 7, 1'b0);
        Rst   = 1'b1;
        Start = 1'b1;
        tick();
        Rst   = 1'b0;
        Start = 1'b0;
        chk_state("rst_r7", ST_IDLE, 0);

        // Normal operation after a mid-operation reset.
        accept(2'b00);
        rounds(1, exp_nr(2'b00) - 1, 1'b0);
        finish_block(exp_nr(2'b00));
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk_state("ack_idle_c", ST_IDLE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
